// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: address decode, transfer qualification,
// two-deep address/data pipeline and the two-cycle ERROR response with a saturating counter.
module ahb_slave_interface #(
  parameter logic [31:0] SLV_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV_SPAN = 32'h0400_0000,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  input  logic                Hreadyin,
  input  logic [1:0]          Htrans,
  input  logic                Hwrite,
  input  logic [2:0]          Hsize,
  input  logic [31:0]         Haddr,
  input  logic [31:0]         Hwdata,
  input  logic [31:0]         Prdata,
  input  logic                Hreadyout_apb,
  output logic                valid,
  output logic [2:0]          tempselx,
  output logic [31:0]         Haddr1,
  output logic [31:0]         Haddr2,
  output logic [31:0]         Hwdata1,
  output logic [31:0]         Hwdata2,
  output logic                Hwritereg,
  output logic [31:0]         Hrdata,
  output logic [1:0]          Hresp,
  output logic                Hreadyout,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {StOkay, StErr1, StErr2} state_e;

  // Region bounds are widened to 34 bits so a window near the top of memory cannot wrap.
  localparam logic [33:0] Bound0 = {2'b00, SLV_BASE};
  localparam logic [33:0] Bound1 = Bound0 + {2'b00, SLV_SPAN};
  localparam logic [33:0] Bound2 = Bound1 + {2'b00, SLV_SPAN};
  localparam logic [33:0] Bound3 = Bound2 + {2'b00, SLV_SPAN};

  state_e              state_q, state_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]         haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
  logic                hwrite_q;
  logic [33:0]         addr_ext;
  logic                act, bad, bad_attr, in_err1;

  assign addr_ext = {2'b00, Haddr};

  always_comb begin
    tempselx = 3'b000;
    if (addr_ext >= Bound0 && addr_ext < Bound1) begin
      tempselx = 3'b001;
    end else if (addr_ext >= Bound1 && addr_ext < Bound2) begin
      tempselx = 3'b010;
    end else if (addr_ext >= Bound2 && addr_ext < Bound3) begin
      tempselx = 3'b100;
    end
  end

  assign bad_attr = (Hsize > 3'd2) ||
                    (Hsize == 3'd1 && Haddr[0]) ||
                    (Hsize == 3'd2 && Haddr[1:0] != 2'b00);
  assign act      = Hreadyin & Htrans[1];
  assign bad      = act & ((tempselx == 3'b000) | bad_attr);
  assign in_err1  = (state_q == StErr1);
  assign valid    = act & ~bad & ~in_err1;

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StOkay:  state_d = bad ? StErr1 : StOkay;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = bad ? StErr1 : StOkay;
      default: state_d = StOkay;
    endcase
    if (state_d == StErr1 && !in_err1 && err_cnt_q != {ERRCNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= StOkay;
      err_cnt_q <= '0;
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      haddr1_q  <= Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= Hwrite;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;
  assign Hrdata    = Prdata;
  assign Hresp     = (state_q == StOkay) ? 2'b00 : 2'b01;
  assign Hreadyout = Hreadyout_apb & ~in_err1;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed bench for ahb_slave_interface: stimulus pushes expected values into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_ahb_slave_interface;

  localparam int SelValid = 0, SelSel = 1, SelA1 = 2, SelA2 = 3, SelD1 = 4, SelD2 = 5;
  localparam int SelWr = 6, SelRd = 7, SelResp = 8, SelRdy = 9, SelCnt = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        Hreadyout_apb;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg, Hreadyout;
  logic [1:0]  Hresp;
  logic [7:0]  err_cnt;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  ahb_slave_interface dut (
    .Hclk          (Hclk),
    .Hresetn       (Hresetn),
    .Hreadyin      (Hreadyin),
    .Htrans        (Htrans),
    .Hwrite        (Hwrite),
    .Hsize         (Hsize),
    .Haddr         (Haddr),
    .Hwdata        (Hwdata),
    .Prdata        (Prdata),
    .Hreadyout_apb (Hreadyout_apb),
    .valid         (valid),
    .tempselx      (tempselx),
    .Haddr1        (Haddr1),
    .Haddr2        (Haddr2),
    .Hwdata1       (Hwdata1),
    .Hwdata2       (Hwdata2),
    .Hwritereg     (Hwritereg),
    .Hrdata        (Hrdata),
    .Hresp         (Hresp),
    .Hreadyout     (Hreadyout),
    .err_cnt       (err_cnt)
  );

  always #5 Hclk = ~Hclk;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SelValid: return {31'b0, valid};
      SelSel:   return {29'b0, tempselx};
      SelA1:    return Haddr1;
      SelA2:    return Haddr2;
      SelD1:    return Hwdata1;
      SelD2:    return Hwdata2;
      SelWr:    return {31'b0, Hwritereg};
      SelRd:    return Hrdata;
      SelResp:  return {30'b0, Hresp};
      SelRdy:   return {31'b0, Hreadyout};
      default:  return {24'b0, err_cnt};
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is checked at that cycle's negedge.
  always @(negedge Hclk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.tag, a, e.exp);
      end
    end
  end

  task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and drive a new address/data phase.
  task automatic cyc(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge Hclk);
    #1;
    Htrans = trans;
    Hwrite = wr;
    Hsize  = size;
    Haddr  = addr;
    Hwdata = wdata;
  endtask

  task automatic idle();
    cyc(2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic reset_pulse();
    @(posedge Hclk);
    #1;
    Hresetn = 1'b0;
    #2;
    Hresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Hresetn       = 1'b0;
    Hreadyin      = 1'b1;
    Hreadyout_apb = 1'b1;
    Htrans        = 2'($urandom);
    Hwrite        = 1'($urandom);
    Hsize         = 3'($urandom);
    Haddr         = $urandom;
    Hwdata        = $urandom;
    Prdata        = 32'h0;

    // Reset with random inputs toggling.
    repeat (3) cyc(2'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
    expect_v("rst_haddr1", SelA1, 0);
    expect_v("rst_haddr2", SelA2, 0);
    expect_v("rst_hwdata1", SelD1, 0);
    expect_v("rst_hwdata2", SelD2, 0);
    expect_v("rst_hwritereg", SelWr, 0);
    expect_v("rst_hresp", SelResp, 0);
    expect_v("rst_errcnt", SelCnt, 0);
    idle();
    Hresetn = 1'b1;
    expect_v("rel_valid_idle", SelValid, 0);
    expect_v("rel_hresp", SelResp, 0);
    expect_v("rel_haddr1", SelA1, 0);

    // Single write.
    cyc(2'b10, 1'b1, 3'd2, 32'h8000_0010, 32'h0);
    expect_v("wr_valid", SelValid, 1);
    expect_v("wr_sel", SelSel, 3'b001);
    cyc(2'b00, 1'b0, 3'd0, 32'h0, 32'hA5A5_0001);
    expect_v("wr_haddr1", SelA1, 32'h8000_0010);
    expect_v("wr_hwritereg", SelWr, 1);
    expect_v("wr_idle_valid", SelValid, 0);
    idle();
    expect_v("wr_haddr2", SelA2, 32'h8000_0010);
    expect_v("wr_hwdata1", SelD1, 32'hA5A5_0001);
    expect_v("wr_haddr1_next", SelA1, 0);
    idle();
    expect_v("wr_hwdata2", SelD2, 32'hA5A5_0001);

    // Back-to-back mixed burst.
    cyc(2'b10, 1'b1, 3'd2, 32'h8400_0000, 32'h0);
    expect_v("b1_sel", SelSel, 3'b010);
    expect_v("b1_valid", SelValid, 1);
    cyc(2'b11, 1'b1, 3'd2, 32'h8400_0004, 32'h1111_0000);
    expect_v("b2_sel", SelSel, 3'b010);
    expect_v("b2_haddr1", SelA1, 32'h8400_0000);
    cyc(2'b10, 1'b0, 3'd2, 32'h8800_0000, 32'h2222_0000);
    Prdata = 32'hDEAD_BEEF;
    expect_v("b3_sel", SelSel, 3'b100);
    expect_v("b3_valid", SelValid, 1);
    expect_v("b3_haddr1", SelA1, 32'h8400_0004);
    expect_v("b3_haddr2", SelA2, 32'h8400_0000);
    expect_v("b3_hrdata", SelRd, 32'hDEAD_BEEF);
    expect_v("b3_hwritereg", SelWr, 1);
    expect_v("b3_hwdata1", SelD1, 32'h1111_0000);
    idle();
    Prdata = 32'h0;
    expect_v("b4_haddr1", SelA1, 32'h8800_0000);
    expect_v("b4_haddr2", SelA2, 32'h8400_0004);
    expect_v("b4_hwritereg", SelWr, 0);
    expect_v("b4_hrdata", SelRd, 0);
    expect_v("b4_hwdata1", SelD1, 32'h2222_0000);
    expect_v("b4_hwdata2", SelD2, 32'h1111_0000);

    // Unmapped address.
    cyc(2'b10, 1'b1, 3'd2, 32'h9000_0000, 32'h0);
    expect_v("um_valid", SelValid, 0);
    expect_v("um_sel", SelSel, 0);
    expect_v("um_hresp_addr", SelResp, 0);
    idle();
    expect_v("um_err1_hresp", SelResp, 1);
    expect_v("um_err1_rdy", SelRdy, 0);
    expect_v("um_err1_cnt", SelCnt, 1);
    idle();
    expect_v("um_err2_hresp", SelResp, 1);
    expect_v("um_err2_rdy", SelRdy, 1);
    idle();
    expect_v("um_okay_hresp", SelResp, 0);
    expect_v("um_okay_cnt", SelCnt, 1);

    // Misaligned and oversize, starting from a fresh counter.
    reset_pulse();
    expect_v("mis_cnt_cleared", SelCnt, 0);
    cyc(2'b10, 1'b0, 3'd2, 32'h8000_0002, 32'h0);
    expect_v("mis_valid", SelValid, 0);
    idle();
    expect_v("mis_err1_hresp", SelResp, 1);
    expect_v("mis_err1_rdy", SelRdy, 0);
    idle();
    expect_v("mis_err2_hresp", SelResp, 1);
    cyc(2'b10, 1'b0, 3'd3, 32'h8000_0000, 32'h0);
    expect_v("ovs_valid", SelValid, 0);
    expect_v("ovs_hresp_okay", SelResp, 0);
    cyc(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'h0);
    expect_v("ovs_err1_hresp", SelResp, 1);
    expect_v("ovs_err1_valid_forced", SelValid, 0);
    expect_v("ovs_err1_cnt", SelCnt, 2);
    cyc(2'b10, 1'b0, 3'd2, 32'h8000_0020, 32'h0);
    expect_v("ovs_err2_valid", SelValid, 1);
    expect_v("ovs_err2_hresp", SelResp, 1);
    expect_v("ovs_err2_rdy", SelRdy, 1);
    idle();
    expect_v("ovs_okay_hresp", SelResp, 0);
    expect_v("ovs_okay_cnt", SelCnt, 2);

    // Hreadyin low and BUSY never raise an error.
    Hreadyin = 1'b0;
    cyc(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'h0);
    expect_v("nrdy_valid", SelValid, 0);
    cyc(2'b01, 1'b0, 3'd2, 32'h9000_0000, 32'h0);
    Hreadyin = 1'b1;
    expect_v("busy_valid", SelValid, 0);
    expect_v("nrdy_hresp", SelResp, 0);
    idle();
    expect_v("busy_hresp", SelResp, 0);
    expect_v("busy_cnt", SelCnt, 2);

    // Region boundaries.
    cyc(2'b10, 1'b0, 3'd2, 32'h7FFF_FFFC, 32'h0);
    expect_v("below_sel", SelSel, 0);
    expect_v("below_valid", SelValid, 0);
    idle();
    idle();
    idle();
    cyc(2'b10, 1'b0, 3'd2, 32'h8BFF_FFFC, 32'h0);
    expect_v("last_valid", SelValid, 1);
    expect_v("last_sel", SelSel, 3'b100);
    cyc(2'b10, 1'b0, 3'd2, 32'h8C00_0000, 32'h0);
    expect_v("end_valid", SelValid, 0);
    expect_v("end_sel", SelSel, 0);
    idle();
    expect_v("end_err1_hresp", SelResp, 1);
    idle();
    Hreadyout_apb = 1'b0;
    expect_v("end_err2_rdy_apb_low", SelRdy, 0);
    idle();
    Hreadyout_apb = 1'b1;
    expect_v("end_okay_hresp", SelResp, 0);
    expect_v("end_cnt", SelCnt, 4);

    // Saturation: 260 more errors on top of 4.
    for (int i = 0; i < 260; i++) begin
      cyc(2'b10, 1'b1, 3'd2, 32'h9000_0000, 32'h0);
      idle();
      idle();
    end
    idle();
    expect_v("sat_cnt", SelCnt, 255);
    cyc(2'b10, 1'b1, 3'd2, 32'h9000_0000, 32'h0);
    idle();
    expect_v("sat_err1_hresp", SelResp, 1);
    expect_v("sat_hold", SelCnt, 255);

    // Reset asserted in ERR1 clears everything at once.
    idle();
    idle();
    cyc(2'b10, 1'b1, 3'd2, 32'h9000_0000, 32'h0);
    @(posedge Hclk);
    #1;
    Htrans  = 2'b00;
    Hresetn = 1'b0;
    expect_v("rstmid_hresp", SelResp, 0);
    expect_v("rstmid_cnt", SelCnt, 0);
    expect_v("rstmid_rdy", SelRdy, 1);
    idle();
    Hresetn = 1'b1;
    expect_v("rstmid_rel_hresp", SelResp, 0);
    idle();
    expect_v("rstmid_after_hresp", SelResp, 0);
    expect_v("rstmid_after_cnt", SelCnt, 0);

    @(posedge Hclk);
    @(negedge Hclk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
      failures += q.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

AHB-side front end of the AHB-to-APB bridge. It sits directly upstream of the APB FSM controller. It samples AHB address and data phases, decodes the target peripheral, and produces the `valid` qualifier. It also builds the two-deep address/data pipeline (`Haddr1/2`, `Hwdata1/2`, `Hwritereg`) that the controller uses for pipelined writes, and it generates the two-cycle AHB ERROR response for illegal transfers.

## Interface
Parameters:
- `SLV_BASE`, default 32'h8000_0000: base of the bridge address window.
- `SLV_SPAN`, default 32'h0400_0000: size of each of the 3 peripheral regions, which are contiguous from `SLV_BASE`.
- `ERRCNT_W`, default 8: width of the saturating error counter.

Ports:
- `Hclk` in 1: bus clock. All state updates on its rising edge.
- `Hresetn` in 1: asynchronous, active-low reset.
- `Hreadyin` in 1: bus HREADY fed back from the interconnect.
- `Htrans` in 2: transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `Hwrite` in 1: transfer direction; 1 = write.
- `Hsize` in 3: transfer size.
- `Haddr` in 32: address phase address.
- `Hwdata` in 32: data phase write data.
- `Prdata` in 32: APB read data.
- `Hreadyout_apb` in 1: ready from the APB FSM controller.
- `valid` out 1: current address phase is a legal bridge transfer (combinational).
- `tempselx` out 3: one-hot peripheral select decoded from `Haddr` (combinational).
- `Haddr1`, `Haddr2` out 32: `Haddr` delayed by 1 and 2 cycles.
- `Hwdata1`, `Hwdata2` out 32: `Hwdata` delayed by 1 and 2 cycles.
- `Hwritereg` out 1: `Hwrite` delayed by 1 cycle.
- `Hrdata` out 32: equal to `Prdata` (combinational pass-through).
- `Hresp` out 2: 00 = OKAY, 01 = ERROR.
- `Hreadyout` out 1: `Hreadyout_apb & ~err1`, where `err1` means the FSM is in ERR1.
- `err_cnt` out ERRCNT_W: count of ERROR responses issued, saturating.

## Operation
Address decode (combinational):
- `tempselx` = 001 for `[SLV_BASE, SLV_BASE+SPAN)`.
- `tempselx` = 010 for the next `SPAN`.
- `tempselx` = 100 for the third `SPAN`.
- `tempselx` = 000 for any other address.

Transfer classification (combinational):
- `act` = `Hreadyin & Htrans[1]` (NONSEQ or SEQ). BUSY and IDLE never set `act`.
- `bad` = `act` and any of:
  - `tempselx`==000;
  - `Hsize`>2;
  - `Hsize`==1 with `Haddr[0]`≠0;
  - `Hsize`==2 with `Haddr[1:0]`≠0.
- `valid` = `act & ~bad & (state != ERR1)`.

Pipeline registers, loaded every cycle with no enable, so the timing is exact regardless of wait states:
- `Haddr1`←`Haddr`, `Haddr2`←`Haddr1`.
- `Hwdata1`←`Hwdata`, `Hwdata2`←`Hwdata1`.
- `Hwritereg`←`Hwrite`.

Error FSM, states OKAY / ERR1 / ERR2:
- OKAY: `Hresp`=00. Go to ERR1 when `bad`, otherwise stay.
- ERR1: `Hresp`=01 and `Hreadyout`=0. Inputs are ignored and `valid` is forced to 0. Always go to ERR2.
- ERR2: `Hresp`=01 and `Hreadyout`=`Hreadyout_apb`. The current address phase is evaluated normally: go to ERR1 if `bad`, otherwise go to OKAY. A legal transfer here asserts `valid`.

Error counter:
- `err_cnt` increments by 1 on each OKAY→ERR1 or ERR2→ERR1 transition.
- It saturates at all-ones and never wraps.

## Timing
Reset (`Hresetn`=0, asynchronous, takes effect immediately):
- `Haddr1`, `Haddr2`, `Hwdata1`, `Hwdata2` = 0; `Hwritereg` = 0.
- FSM = OKAY, `Hresp` = 00, `err_cnt` = 0.
- `valid`, `tempselx`, `Hrdata` and `Hreadyout` follow their combinational equations.
- Reset asserted during ERR1 or ERR2 returns the FSM to OKAY in the same instant, and `Hresp`=00 on release.

Latencies:
- `valid` and `tempselx`: 0 cycles from the address phase.
- `Haddr1`: 1 edge; `Haddr2`: 2 edges.
- `Hwdata1`: 1 edge after the data phase.
- `Hrdata`: 0 cycles from `Prdata`.

ERROR response:
- Exactly 2 cycles: ERR1 (`Hreadyout`=0), then ERR2 (`Hreadyout`=1 when the controller is ready).
- `Hresp` is stable at 01 across both cycles and returns to 00 on the cycle after ERR2 unless a new `bad` transfer is sampled in ERR2.

Simultaneous or boundary events:
- `Hreadyin`=0: `act`=0, so neither `valid` nor an error is raised for that cycle.
- Last word of region 3 (`SLV_BASE+3*SPAN-4`): legal.
- `SLV_BASE+3*SPAN`: `bad`.

## Test plan
- **Reset:** hold `Hresetn`=0 with random inputs, then release → all pipeline regs 0, `Hresp`=00, `err_cnt`=0; `valid`=0 while `Htrans`=00.
- **Single write:** NONSEQ write to 32'h8000_0010, `Hsize`=2, `Hwdata`=32'hA5A5_0001 in the next cycle → `valid`=1 and `tempselx`=001 in the address cycle; `Haddr1`=32'h8000_0010 and `Hwritereg`=1 after 1 edge; `Haddr2`=32'h8000_0010 after 2 edges; `Hwdata1`=32'hA5A5_0001 one edge after the data phase.
- **Back-to-back mixed burst:** NONSEQ then SEQ to 32'h8400_0000, 32'h8400_0004 (write), then a read at 32'h8800_0000 → `tempselx` 010, 010, 100; the `Haddr1`/`Haddr2` shift sequence matches exactly; `Hrdata` tracks `Prdata`=32'hDEAD_BEEF in the same cycle.
- **Unmapped address:** NONSEQ to 32'h9000_0000 → `valid`=0, then ERR1 (`Hresp`=01, `Hreadyout`=0), then ERR2 (`Hresp`=01, `Hreadyout`=1), then OKAY; `err_cnt`=1.
- **Misaligned and oversize:** `Hsize`=2 at 32'h8000_0002 and `Hsize`=3 at 32'h8000_0000, each followed by IDLE → each gives a 2-cycle ERROR; `err_cnt`=2. Also: a legal NONSEQ presented in ERR2 → `valid`=1 and the FSM goes to OKAY; BUSY/IDLE with `Hreadyin`=0 → no error.
- **Saturation and reset mid-error:** 260 bad transfers → `err_cnt` holds 255. Assert `Hresetn` during ERR1 → `Hresp`=00 immediately and `err_cnt`=0.
